// File: rtl/alu_iterative.sv
// alu_iterative: multi-cycle ALU with single-cycle add/logic ops and bit-serial shifts
module alu_iterative #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [6:0]       i_control_signal,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_sign
);
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
    state_t r_state, w_next;
    logic [6:0]         r_cs;
    logic [WIDTH-1:0]   r_a, r_b, r_sh, r_result;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_carry, r_zero, r_sign;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_sh1, w_exec;
    logic               w_shift_req, w_last;
    assign w_shift_req = i_control_signal[2:0] == 3'b011 && i_b[SHAMT_W-1:0] != '0;
    assign w_last      = r_cnt == SHAMT_W'(1);
    assign w_sum       = r_cs[3] ? {1'b0, ~r_b} + (WIDTH+1)'(1) : {1'b0, r_a} + {1'b0, r_b};
    assign w_sh1       = r_cs[4] ? {r_sh[WIDTH-2:0], 1'b0} : {r_cs[5] & r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
    // op 011 only reaches EXEC with a zero shift amount, so it passes a through
    assign w_exec      = r_cs[1:0] == 2'b00 ? w_sum[WIDTH-1:0] :
                         r_cs[1:0] == 2'b01 ? r_a & r_b :
                         r_cs[1:0] == 2'b10 ? r_a ^ r_b : r_a;
    assign o_result    = r_result;
    assign o_carry     = r_carry;
    assign o_zero      = r_zero;
    assign o_sign      = r_sign;
    always_comb begin
        o_busy = r_state == EXEC || r_state == SHIFT;
        o_done = r_state == DONE;
        w_next = r_state == IDLE  ? (i_start ? (w_shift_req ? SHIFT : EXEC) : IDLE) :
                 r_state == EXEC  ? DONE :
                 r_state == SHIFT ? (w_last ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
            r_sign   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_a   <= i_a;
                r_b   <= i_b;
                r_cs  <= i_control_signal;
                r_sh  <= i_a;
                r_cnt <= i_b[SHAMT_W-1:0];
            end
            if (r_state == EXEC && !r_cs[2]) begin
                r_result <= w_exec;
                r_zero   <= w_exec == '0;
                r_sign   <= w_exec[WIDTH-1];
                if (r_cs[1:0] == 2'b00 && r_cs[6]) r_carry <= w_sum[WIDTH];
            end
            if (r_state == SHIFT) begin
                r_sh  <= w_sh1;
                r_cnt <= r_cnt - SHAMT_W'(1);
                if (w_last) begin
                    r_result <= w_sh1;
                    r_zero   <= w_sh1 == '0;
                    r_sign   <= w_sh1[WIDTH-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: directed table, corner sequences and random ops against an arithmetic model
module tb_alu_iterative;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  cs = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, carry, zero, sign;
    logic [31:0] result;
    int          n_pass = 0, n_tot = 0;
    logic [31:0] m_res;
    logic        m_carry, m_zero, m_sign;

    alu_iterative #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_control_signal(cs), .i_a(a), .i_b(b),
        .o_busy(busy), .o_done(done), .o_result(result), .o_carry(carry), .o_zero(zero), .o_sign(sign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  cs;
        logic [31:0] a, b;
        int          poke;
        logic [31:0] exp_res;
        logic        exp_carry;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_res = '0; m_carry = 1'b0; m_zero = 1'b1; m_sign = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " result"}, result, m_res);
        chk({tag, " carry"}, 32'(carry), 32'(m_carry));
        chk({tag, " zero"}, 32'(zero), 32'(m_zero));
        chk({tag, " sign"}, 32'(sign), 32'(m_sign));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [6:0] c, input logic [31:0] x, input logic [31:0] y, input int poke);
        logic [32:0] s;
        int n, exp_lat, lat, nbusy;
        n = int'(y[4:0]);
        exp_lat = 2;
        if (c[2:0] == 3'b011 && n > 0) exp_lat = n + 1;
        if (!c[2]) begin
            case (c[1:0])
                2'b00: begin
                    s = c[3] ? 33'(-{1'b0, y}) & 33'h0_FFFF_FFFF | (y == 0 ? 33'h1_0000_0000 : 33'h0) : {1'b0, x} + {1'b0, y};
                    m_res = s[31:0];
                    if (c[6]) m_carry = s[32];
                end
                2'b01: m_res = x & y;
                2'b10: m_res = x ^ y;
                default: m_res = c[4] ? x << n : c[5] ? 32'($signed(x) >>> n) : x >> n;
            endcase
            m_zero = m_res == 0;
            m_sign = m_res[31];
        end
        start = 1'b1; cs = c; a = x; b = y;
        @(negedge clk);
        lat = 1; nbusy = 0;
        while (!done && lat < 40) begin
            start = (lat == poke);
            cs = 7'($urandom); a = $urandom; b = $urandom;
            nbusy += int'(busy);
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency cs=%b", c), lat, exp_lat);
        chk($sformatf("busy cycles cs=%b", c), nbusy, exp_lat - 1);
        check_outputs($sformatf("op cs=%b", c));
        start = (lat == poke);
        @(negedge clk);
        start = 1'b0;
        chk("done/busy after done", {done, busy}, 2'b00);
        @(negedge clk);
        chk("idle after done", {done, busy}, 2'b00);
    endtask

    initial begin
        logic saw_done;
        logic [6:0] rc;
        int op;
        tbl[0]  = '{7'b1000000, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 1'b0};
        tbl[1]  = '{7'b1000000, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1'b1};
        tbl[2]  = '{7'b0000010, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, 32'hFFFFFFFF, 1'b1};
        tbl[3]  = '{7'b0001000, 32'h00000000, 32'h00000005, 0, 32'hFFFFFFFB, 1'b1};
        tbl[4]  = '{7'b0000001, 32'hFF00FF00, 32'h0FF00FF0, 0, 32'h0F000F00, 1'b1};
        tbl[5]  = '{7'b0100011, 32'h80000001, 32'h00000004, 0, 32'hF8000000, 1'b1};
        tbl[6]  = '{7'b0000011, 32'h80000001, 32'h00000004, 0, 32'h08000000, 1'b1};
        tbl[7]  = '{7'b0010011, 32'h80000001, 32'h0000001F, 0, 32'h80000000, 1'b1};
        tbl[8]  = '{7'b0010011, 32'h80000001, 32'h00000000, 0, 32'h80000001, 1'b1};
        tbl[9]  = '{7'b0000011, 32'hFFFF0000, 32'h00000008, 3, 32'h00FFFF00, 1'b1};
        tbl[10] = '{7'b1000000, 32'h00001234, 32'h00000000, 0, 32'h00001234, 1'b0};
        tbl[11] = '{7'b0111111, 32'hDEADBEEF, 32'h00000003, 2, 32'h00001234, 1'b0};
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outputs("reset");
        chk("reset done/busy", {done, busy}, 2'b00);
        foreach (tbl[i]) begin
            run_op(tbl[i].cs, tbl[i].a, tbl[i].b, tbl[i].poke);
            chk($sformatf("table %0d result", i), result, tbl[i].exp_res);
            chk($sformatf("table %0d carry", i), 32'(carry), 32'(tbl[i].exp_carry));
        end
        // abort a long shift: a second start while busy and then a reset mid-shift
        saw_done = 1'b0;
        start = 1'b1; cs = 7'b0010011; a = 32'h80000001; b = 32'd20;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            saw_done |= done;
            if (c == 6) chk("busy after ignored start", 32'(busy), 32'd1);
            start = (c == 5);
            cs = 7'b1000000; a = 32'h1; b = 32'h1;
            rst = (c == 10);
        end
        start = 1'b0; rst = 1'b0;
        model_reset();
        chk("no done on abort", 32'(saw_done), 32'd0);
        chk("abort done/busy", {done, busy}, 2'b00);
        check_outputs("abort");
        run_op(7'b1000000, 32'h00000010, 32'h00000020, 0);
        chk("post-reset add", result, 32'h00000030);
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            rc = 7'($urandom);
            rc[2:0] = op > 3 ? 3'(4 + $urandom_range(0, 3)) : 3'(op);
            run_op(rc, $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 31)) : $urandom, (i % 5 == 0) ? $urandom_range(1, 4) : 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Sequential ALU that consumes the 7-bit control word produced by the ALU control decoder and executes one operation per start request.
- Add, AND, XOR and two's-complement ops complete in one cycle.
- Shifts run iteratively, one bit position per cycle, to save area over a barrel shifter.
- Sits in the execute stage, between the ALU control decoder/register file and the writeback/branch logic; the controller stalls on busy.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, width of shift-amount field taken from b[SHAMT_W-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- control_signal  input  7  {carry_out_select, logic_arith, direction, carry_in, operation[2:0]}.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt / imm / shamt).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  registered result, held until the next done.
- carry  output  1  carry flag register.
- zero  output  1  result == 0, registered with result.
- sign  output  1  result[WIDTH-1], registered with result.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, result=0, carry=0, zero=1, sign=0. An operation in progress is aborted and no done is issued.
- Operand and control latch: on an accepted start (IDLE & start), latch a, b and control_signal. Later changes to the inputs are ignored.
- Operation decode (latched control):
  - op 000, carry_in 0: a+b.
  - op 000, carry_in 1: (~b)+1 (comp).
  - op 001: a&b.
  - op 010: a^b.
  - op 011: shift a by b[SHAMT_W-1:0].
  - op 1xx: no-op, result unchanged.
- Adder: WIDTH+1-bit sum. When carry_out_select=1, carry <= bit WIDTH of the sum; otherwise carry is held. Shifts and logic ops never change carry.
- Shift: direction=1 is a logical left shift (zero fill). direction=0 with logic_arith=0 is a logical right shift. direction=0 with logic_arith=1 is an arithmetic right shift (sign fill).
- FSM states are IDLE, EXEC, SHIFT, DONE:
  - IDLE: on start, go to EXEC (non-shift op, and shift with shamt=0) or SHIFT (shift with shamt>0, counter<=shamt, shift register<=a).
  - EXEC: compute the result, register result/zero/sign (and carry per the adder rule), go to DONE.
  - SHIFT: each cycle, shift the register by 1 and decrement the counter. When the counter reaches 1 on the shifting edge, go to DONE with result<=final value.
  - DONE: done=1 for exactly one cycle, then IDLE. A start asserted during DONE is ignored.
- Latency (start edge to done high):
  - non-shift op: 2 cycles.
  - shift with shamt=0: 2 cycles; result=a.
  - shift with shamt=n>0: n+1 cycles.
  - Maximum latency is 32 cycles (shamt=31).
- No-op (0111111, op 111): passes through EXEC/DONE; done pulses, but result, zero, sign and carry are unchanged.
- busy is 1 in EXEC and SHIFT, 0 in IDLE and DONE. start while busy is ignored and not queued.
- Overflow is ignored; wrap-around is modulo 2^WIDTH.
- zero and sign update only on the cycle result updates.

Test Plan:
- Reset, then add 0x7FFFFFFF+0x00000001 with cs=1000000 -> done 2 cycles after start; result=0x80000000, sign=1, zero=0, carry=0.
- Add 0xFFFFFFFF+0x00000001 with cs=1000000, then xor 0xF0F0F0F0^0x0F0F0F0F with cs=0000010 -> first result=0, zero=1, carry=1. Second result=0xFFFFFFFF, carry stays 1 (held).
- Comp with b=0x00000005, cs=0001000 -> result=0xFFFFFFFB, carry unchanged. Then and 0xFF00FF00&0x0FF00FF0 (cs=0000001) -> result=0x0F000F00.
- Shifts on a=0x80000001:
  - shra by b=4 (cs=0100011) -> result=0xF8000000, done 5 cycles after start, busy high 4 cycles.
  - shrl by 4 (cs=0000011) -> result=0x08000000.
  - shll by 31 (cs=0010011) -> result=0x80000000, latency 32 cycles.
  - shll by 0 -> result=0x80000001, latency 2.
- Start a shll by 20; re-pulse start with different operands at cycle 5; assert rst at cycle 10 -> second start ignored, no done issued, outputs return to reset values. A new add started after reset completes normally.
- No-op cs=0111111 after a result of 0x1234 -> done pulses after 2 cycles; result remains 0x1234, flags unchanged.
